perf_sample_ctrl: RTL and testbench

- Sequencer and arbiter for the performance-counter CSR access port. The counter bank exposes a single read/write port, and two requesters share it: the CSR file and an autonomous sampling engine.
- The engine periodically sweeps all hardware counters, or sweeps on a counter-overflow interrupt. Each counter value is emitted as a valid/ready beat addressed to a memory-mapped buffer, for a downstream store unit.
- The block sits between the CSR regfile and the counter bank.

---
 rtl/perf_pkg.sv | 22 ++
 rtl/perf_sample_timer.sv | 29 ++
 rtl/perf_sample_ctrl.sv | 153 +++++++++++++++
 tb/tb_perf_sample_ctrl.sv | 437 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/perf_pkg.sv
// Shared types and default constants for the performance-counter sampling engine.
package perf_pkg;

    localparam int unsigned PerfNumCounters   = 6;
    localparam logic [11:0] PerfCntAddrBase   = 12'hB03;
    localparam int unsigned PerfDataWidth     = 64;
    localparam int unsigned PerfAddrWidth     = 64;
    localparam int unsigned PerfIntervalWidth = 32;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRead = 2'd1,
        StPush = 2'd2
    } perf_state_e;

    typedef struct packed {
        logic [PerfAddrWidth-1:0] addr;
        logic [PerfDataWidth-1:0] data;
        logic                     last;
    } perf_beat_t;

endpackage

// File: rtl/perf_sample_timer.sv
// Reload down-counter: pulses trig_o once every interval_i cycles while running.
module perf_sample_timer #(
    parameter int unsigned IntervalWidth = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     enable_i,
    input  logic [IntervalWidth-1:0] interval_i,
    output logic                     trig_o
);

    logic [IntervalWidth-1:0] cnt_q;
    logic                     run;

    assign run    = enable_i && (interval_i != '0);
    assign trig_o = run && (cnt_q == IntervalWidth'(1));

    // A zero count only exists straight out of reset; load instead of wrapping.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (!run || trig_o || (cnt_q == '0)) begin
            cnt_q <= interval_i;
        end else begin
            cnt_q <= cnt_q - IntervalWidth'(1);
        end
    end

endmodule

// File: rtl/perf_sample_ctrl.sv
// Shares the counter-bank port between the CSR file and a sweep engine that
// streams every counter value to a memory buffer as valid/ready beats.
module perf_sample_ctrl
    import perf_pkg::*;
#(
    parameter int unsigned NumCounters   = PerfNumCounters,
    parameter logic [11:0] CntAddrBase   = PerfCntAddrBase,
    parameter int unsigned DataWidth     = PerfDataWidth,
    parameter int unsigned IntervalWidth = PerfIntervalWidth
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     enable_i,
    input  logic [IntervalWidth-1:0] interval_i,
    input  logic [63:0]              base_addr_i,
    input  logic                     irq_i,
    input  logic                     csr_req_i,
    input  logic                     csr_we_i,
    input  logic [11:0]              csr_addr_i,
    input  logic [DataWidth-1:0]     csr_wdata_i,
    output logic                     csr_gnt_o,
    output logic [DataWidth-1:0]     csr_rdata_o,
    output logic [11:0]              pc_addr_o,
    output logic                     pc_we_o,
    output logic [DataWidth-1:0]     pc_wdata_o,
    input  logic [DataWidth-1:0]     pc_rdata_i,
    output logic                     smp_valid_o,
    input  logic                     smp_ready_i,
    output logic [63:0]              smp_addr_o,
    output logic [DataWidth-1:0]     smp_data_o,
    output logic                     smp_last_o,
    output logic                     busy_o,
    output logic [15:0]              drop_cnt_o
);

    localparam int unsigned   IdxW    = (NumCounters > 1) ? $clog2(NumCounters) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NumCounters - 1);

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    perf_state_e          state_q, state_d;
    logic [IdxW-1:0]      idx_q, idx_d;
    logic [63:0]          base_q, base_d;
    logic [DataWidth-1:0] data_q, data_d;
    logic [15:0]          drop_q;
    logic                 irq_q;
    logic                 tmr_trig;
    logic                 irq_trig;
    logic                 trig;
    perf_beat_t           beat;

    perf_sample_timer #(
        .IntervalWidth(IntervalWidth)
    ) u_timer (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .enable_i  (enable_i),
        .interval_i(interval_i),
        .trig_o    (tmr_trig)
    );

    // Periodic and interrupt triggers landing together merge into one event.
    assign irq_trig = enable_i && irq_i && !irq_q;
    assign trig     = tmr_trig || irq_trig;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            idx_q   <= '0;
            base_q  <= '0;
            data_q  <= '0;
            drop_q  <= '0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            base_q  <= base_d;
            data_q  <= data_d;
            irq_q   <= irq_i;
            if (trig && (state_q != StIdle)) begin
                drop_q <= sat_inc16(drop_q);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        base_d  = base_q;
        data_d  = data_q;
        unique case (state_q)
            StIdle: begin
                if (trig) begin
                    base_d  = base_addr_i;
                    idx_d   = '0;
                    state_d = StRead;
                end
            end
            StRead: begin
                if (!enable_i) begin
                    state_d = StIdle;
                end else if (!csr_req_i) begin
                    data_d  = pc_rdata_i;
                    state_d = StPush;
                end
            end
            StPush: begin
                if (smp_ready_i) begin
                    if ((idx_q == LastIdx) || !enable_i) begin
                        state_d = StIdle;
                    end else begin
                        idx_d   = idx_q + IdxW'(1);
                        state_d = StRead;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // The CSR file always wins the counter-bank port.
    always_comb begin
        pc_addr_o   = '0;
        pc_we_o     = 1'b0;
        pc_wdata_o  = '0;
        csr_rdata_o = '0;
        if (csr_req_i) begin
            pc_addr_o   = csr_addr_i;
            pc_we_o     = csr_we_i;
            pc_wdata_o  = csr_wdata_i;
            csr_rdata_o = pc_rdata_i;
        end else if (state_q == StRead) begin
            pc_addr_o = CntAddrBase + 12'(idx_q);
        end
    end

    always_comb begin
        beat.addr = base_q + (PerfAddrWidth'(idx_q) << 3);
        beat.data = PerfDataWidth'(data_q);
        beat.last = (idx_q == LastIdx);
    end

    assign csr_gnt_o   = csr_req_i;
    assign smp_valid_o = (state_q == StPush);
    assign smp_addr_o  = beat.addr;
    assign smp_data_o  = DataWidth'(beat.data);
    assign smp_last_o  = smp_valid_o && beat.last;
    assign busy_o      = (state_q != StIdle);
    assign drop_cnt_o  = drop_q;

endmodule

// File: tb/tb_perf_sample_ctrl.sv
// Randomized bench for perf_sample_ctrl with a behavioural sweep model and beat scoreboard.
module tb_perf_sample_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        enable_i = 1'b0;
    logic [31:0] interval_i = '0;
    logic [63:0] base_addr_i = '0;
    logic        irq_i = 1'b0;
    logic        csr_req_i = 1'b0;
    logic        csr_we_i = 1'b0;
    logic [11:0] csr_addr_i = '0;
    logic [63:0] csr_wdata_i = '0;
    logic        csr_gnt_o;
    logic [63:0] csr_rdata_o;
    logic [11:0] pc_addr_o;
    logic        pc_we_o;
    logic [63:0] pc_wdata_o;
    logic [63:0] pc_rdata_i;
    logic        smp_valid_o;
    logic        smp_ready_i = 1'b0;
    logic [63:0] smp_addr_o;
    logic [63:0] smp_data_o;
    logic        smp_last_o;
    logic        busy_o;
    logic [15:0] drop_cnt_o;

    typedef struct packed {
        logic [63:0] addr;
        logic [63:0] data;
        logic        last;
    } beat_t;

    int          total = 0;
    int          bad = 0;
    beat_t       got_q[$];
    logic [63:0] bank[6];

    perf_sample_ctrl dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .enable_i(enable_i), .interval_i(interval_i),
        .base_addr_i(base_addr_i), .irq_i(irq_i), .csr_req_i(csr_req_i), .csr_we_i(csr_we_i),
        .csr_addr_i(csr_addr_i), .csr_wdata_i(csr_wdata_i), .csr_gnt_o(csr_gnt_o),
        .csr_rdata_o(csr_rdata_o), .pc_addr_o(pc_addr_o), .pc_we_o(pc_we_o),
        .pc_wdata_o(pc_wdata_o), .pc_rdata_i(pc_rdata_i), .smp_valid_o(smp_valid_o),
        .smp_ready_i(smp_ready_i), .smp_addr_o(smp_addr_o), .smp_data_o(smp_data_o),
        .smp_last_o(smp_last_o), .busy_o(busy_o), .drop_cnt_o(drop_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // Counter bank: mhpmcounter3..8 at 0xB03..0xB08, read combinationally.
    always_comb begin
        case (pc_addr_o)
            12'hB03: pc_rdata_i = bank[0];
            12'hB04: pc_rdata_i = bank[1];
            12'hB05: pc_rdata_i = bank[2];
            12'hB06: pc_rdata_i = bank[3];
            12'hB07: pc_rdata_i = bank[4];
            12'hB08: pc_rdata_i = bank[5];
            default: pc_rdata_i = 64'h0BAD_0BAD_0BAD_0BAD;
        endcase
    end

    always @(negedge clk_i) begin
        if (rst_ni && smp_valid_o && smp_ready_i) begin
            got_q.push_back({smp_addr_o, smp_data_o, smp_last_o});
        end
    end

    // Expected beat i of a sweep: consecutive 8-byte slots, counter i's value, last on the sixth.
    function automatic beat_t exp_beat(input logic [63:0] base, input int i);
        beat_t b;
        b.addr = base + 64'(i) * 64'd8;
        b.data = bank[i];
        b.last = (i == 5);
        return b;
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_ni      = 1'b0;
        enable_i    = 1'b0;
        irq_i       = 1'b0;
        csr_req_i   = 1'b0;
        csr_we_i    = 1'b0;
        smp_ready_i = 1'b0;
        interval_i  = '0;
        repeat (3) tick();
        rst_ni = 1'b1;
        tick();
        got_q.delete();
    endtask

    task automatic fill_bank(input bit seq);
        for (int i = 0; i < 6; i++) begin
            bank[i] = seq ? 64'(i + 1) : {$urandom(), $urandom()};
        end
    endtask

    task automatic start_irq();
        irq_i = 1'b1;
        tick();
        irq_i = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        int n;
        n = 0;
        while (busy_o && n < 1000) begin
            tick();
            n++;
        end
        ok = !busy_o;
    endtask

    task automatic test_reset();
        rst_ni   = 1'b0;
        enable_i = 1'b1;
        irq_i    = 1'b1;
        repeat (2) tick();
        total++;
        if ({smp_valid_o, busy_o, smp_last_o, csr_gnt_o, pc_we_o} !== 5'b0) begin
            bad++; $display("FAIL reset_ctrl: got %b want 00000", {smp_valid_o, busy_o, smp_last_o, csr_gnt_o, pc_we_o});
        end
        total++;
        if (drop_cnt_o !== 16'h0) begin
            bad++; $display("FAIL reset_drop: got %0h want 0", drop_cnt_o);
        end
        total++;
        if ({smp_addr_o, smp_data_o, pc_addr_o, pc_wdata_o, csr_rdata_o} !== '0) begin
            bad++; $display("FAIL reset_data: addr %0h data %0h pc_addr %0h want all 0", smp_addr_o, smp_data_o, pc_addr_o);
        end
        irq_i = 1'b0;
    endtask

    task automatic test_periodic();
        int n;
        bit ok;
        do_reset();
        fill_bank(1'b1);
        base_addr_i = 64'h8000_0000;
        smp_ready_i = 1'b1;
        interval_i  = 32'd100;
        tick();
        enable_i = 1'b1;
        n = 0;
        while (!busy_o && n < 300) begin
            tick();
            n++;
        end
        total++;
        if (n !== 100) begin
            bad++; $display("FAIL periodic_start: got %0d cycles want 100", n);
        end
        n = 0;
        while (busy_o && n < 100) begin
            tick();
            n++;
        end
        enable_i = 1'b0;
        total++;
        if (n !== 12) begin
            bad++; $display("FAIL periodic_len: got %0d cycles want 12", n);
        end
        total++;
        if (got_q.size() !== 6) begin
            bad++; $display("FAIL periodic_beats: got %0d want 6", got_q.size());
        end
        for (int i = 0; i < 6 && i < got_q.size(); i++) begin
            total++;
            if (got_q[i] !== exp_beat(64'h8000_0000, i)) begin
                bad++; $display("FAIL periodic_beat%0d: got %h want %h", i, got_q[i], exp_beat(64'h8000_0000, i));
            end
        end
        wait_idle(ok);
    endtask

    task automatic test_csr_priority();
        int          n;
        bit          ok;
        logic [63:0] base, wd;
        do_reset();
        fill_bank(1'b0);
        base        = {$urandom(), $urandom()};
        base_addr_i = base;
        smp_ready_i = 1'b1;
        enable_i    = 1'b1;
        wd          = {$urandom(), $urandom()};
        csr_req_i   = 1'b1;
        csr_we_i    = 1'b1;
        csr_addr_i  = 12'hB07;
        csr_wdata_i = wd;
        #1;
        total++;
        if ({csr_gnt_o, pc_we_o, pc_addr_o, pc_wdata_o} !== {1'b1, 1'b1, 12'hB07, wd}) begin
            bad++; $display("FAIL csr_write: got gnt %b we %b addr %h wdata %h want 1 1 b07 %h", csr_gnt_o, pc_we_o, pc_addr_o, pc_wdata_o, wd);
        end
        tick();
        csr_req_i = 1'b0;
        csr_we_i  = 1'b0;
        start_irq();
        n = 0;
        while (pc_addr_o !== 12'hB04 && n < 50) begin
            tick();
            n++;
        end
        total++;
        if (pc_addr_o !== 12'hB04) begin
            bad++; $display("FAIL csr_find_read1: got %h want b04", pc_addr_o);
        end
        csr_req_i  = 1'b1;
        csr_addr_i = 12'hB05;
        #1;
        total++;
        if ({csr_gnt_o, csr_rdata_o, pc_addr_o, pc_we_o} !== {1'b1, bank[2], 12'hB05, 1'b0}) begin
            bad++; $display("FAIL csr_read: got rdata %h addr %h want %h b05", csr_rdata_o, pc_addr_o, bank[2]);
        end
        tick();
        csr_req_i = 1'b0;
        #1;
        total++;
        if ({smp_valid_o, pc_addr_o} !== {1'b0, 12'hB04}) begin
            bad++; $display("FAIL csr_stall: got valid %b addr %h want 0 b04", smp_valid_o, pc_addr_o);
        end
        tick();
        total++;
        if ({smp_valid_o, smp_data_o} !== {1'b1, bank[1]}) begin
            bad++; $display("FAIL csr_resume: got valid %b data %h want 1 %h", smp_valid_o, smp_data_o, bank[1]);
        end
        wait_idle(ok);
        total++;
        if (!ok || got_q.size() !== 6 || drop_cnt_o !== 16'h0) begin
            bad++; $display("FAIL csr_sweep: got idle %b beats %0d drops %0d want 1 6 0", ok, got_q.size(), drop_cnt_o);
        end
        for (int i = 0; i < 6 && i < got_q.size(); i++) begin
            total++;
            if (got_q[i] !== exp_beat(base, i)) begin
                bad++; $display("FAIL csr_beat%0d: got %h want %h", i, got_q[i], exp_beat(base, i));
            end
        end
    endtask

    task automatic test_backpressure();
        int          n;
        bit          ok;
        logic [63:0] base, ha, hd;
        do_reset();
        fill_bank(1'b0);
        base        = {$urandom(), $urandom()};
        base_addr_i = base;
        smp_ready_i = 1'b1;
        enable_i    = 1'b1;
        start_irq();
        n = 0;
        while (!(smp_valid_o && smp_addr_o == base + 64'd24) && n < 50) begin
            tick();
            n++;
        end
        smp_ready_i = 1'b0;
        ha = smp_addr_o;
        hd = smp_data_o;
        total++;
        if ({smp_valid_o, ha, hd} !== {1'b1, base + 64'd24, bank[3]}) begin
            bad++; $display("FAIL bp_beat3: got addr %h data %h want %h %h", ha, hd, base + 64'd24, bank[3]);
        end
        for (int c = 0; c < 20; c++) begin
            tick();
            total++;
            if ({smp_valid_o, smp_addr_o, smp_data_o, pc_addr_o} !== {1'b1, ha, hd, 12'h000}) begin
                bad++; $display("FAIL bp_hold%0d: got valid %b addr %h data %h pc %h", c, smp_valid_o, smp_addr_o, smp_data_o, pc_addr_o);
            end
        end
        smp_ready_i = 1'b1;
        wait_idle(ok);
        total++;
        if (!ok || got_q.size() !== 6) begin
            bad++; $display("FAIL bp_sweep: got idle %b beats %0d want 1 6", ok, got_q.size());
        end
        for (int i = 0; i < 6 && i < got_q.size(); i++) begin
            total++;
            if (got_q[i] !== exp_beat(base, i)) begin
                bad++; $display("FAIL bp_beat%0d: got %h want %h", i, got_q[i], exp_beat(base, i));
            end
        end
    endtask

    task automatic test_irq();
        int          n;
        logic [63:0] base;
        do_reset();
        fill_bank(1'b0);
        enable_i = 1'b1;
        for (int s = 0; s < 2; s++) begin
            base        = (s == 0) ? 64'hFFFF_FFFF_FFFF_FFF0 : {$urandom(), $urandom()};
            base_addr_i = base;
            got_q.delete();
            irq_i = 1'b1;
            for (int c = 0; c < 10; c++) begin
                smp_ready_i = 1'($urandom_range(0, 1));
                tick();
            end
            irq_i = 1'b0;
            n = 0;
            while (busy_o && n < 500) begin
                smp_ready_i = 1'($urandom_range(0, 1));
                tick();
                n++;
            end
            repeat (5) tick();
            total++;
            if ({busy_o, drop_cnt_o} !== 17'h0 || got_q.size() !== 6) begin
                bad++; $display("FAIL irq_sweep%0d: got busy %b drops %0d beats %0d want 0 0 6", s, busy_o, drop_cnt_o, got_q.size());
            end
            for (int i = 0; i < 6 && i < got_q.size(); i++) begin
                total++;
                if (got_q[i] !== exp_beat(base, i)) begin
                    bad++; $display("FAIL irq%0d_beat%0d: got %h want %h", s, i, got_q[i], exp_beat(base, i));
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        fill_bank(1'b0);
        base_addr_i = {$urandom(), $urandom()};
        smp_ready_i = 1'b1;
        interval_i  = 32'd12;
        tick();
        enable_i = 1'b1;
        // Sweep starts after 12 cycles, takes 12, and the next expiry lands on its last handshake.
        repeat (24) tick();
        enable_i = 1'b0;
        total++;
        if ({busy_o, drop_cnt_o} !== {1'b0, 16'd1} || got_q.size() !== 6) begin
            bad++; $display("FAIL b2b_drop: got busy %b drops %0d beats %0d want 0 1 6", busy_o, drop_cnt_o, got_q.size());
        end
    endtask

    task automatic test_abort();
        int          n;
        logic [63:0] base;
        do_reset();
        fill_bank(1'b0);
        base        = {$urandom(), $urandom()};
        base_addr_i = base;
        smp_ready_i = 1'b1;
        enable_i    = 1'b1;
        start_irq();
        n = 0;
        while (pc_addr_o !== 12'hB05 && n < 50) begin
            tick();
            n++;
        end
        enable_i = 1'b0;
        tick();
        total++;
        if ({busy_o, smp_valid_o} !== 2'b00) begin
            bad++; $display("FAIL abort_idle: got busy %b valid %b want 0 0", busy_o, smp_valid_o);
        end
        repeat (20) tick();
        total++;
        if (got_q.size() !== 2) begin
            bad++; $display("FAIL abort_beats: got %0d want 2", got_q.size());
        end
        for (int i = 0; i < 2 && i < got_q.size(); i++) begin
            total++;
            if (got_q[i] !== exp_beat(base, i)) begin
                bad++; $display("FAIL abort_beat%0d: got %h want %h", i, got_q[i], exp_beat(base, i));
            end
        end
    endtask

    task automatic test_drops();
        int          n, ivl, m;
        logic [63:0] base;
        do_reset();
        fill_bank(1'b0);
        base        = {$urandom(), $urandom()};
        base_addr_i = base;
        ivl         = $urandom_range(3, 9);
        interval_i  = 32'(ivl);
        tick();
        enable_i = 1'b1;
        n = 0;
        while (!busy_o && n < 50) begin
            tick();
            n++;
        end
        total++;
        if ({busy_o, drop_cnt_o} !== {1'b1, 16'd0}) begin
            bad++; $display("FAIL drop_start: got busy %b drops %0d want 1 0", busy_o, drop_cnt_o);
        end
        m = $urandom_range(20, 80);
        repeat (m) tick();
        total++;
        if (drop_cnt_o !== 16'(m / ivl)) begin
            bad++; $display("FAIL drop_count: got %0d want %0d (ivl %0d, cycles %0d)", drop_cnt_o, m / ivl, ivl, m);
        end
        interval_i = 32'd1;
        repeat (65600) tick();
        total++;
        if (drop_cnt_o !== 16'hFFFF) begin
            bad++; $display("FAIL drop_sat: got %h want ffff", drop_cnt_o);
        end
        repeat (5) tick();
        total++;
        if ({drop_cnt_o, smp_valid_o, smp_addr_o} !== {16'hFFFF, 1'b1, base}) begin
            bad++; $display("FAIL drop_hold: got drops %h valid %b addr %h want ffff 1 %h", drop_cnt_o, smp_valid_o, smp_addr_o, base);
        end
        #2;
        rst_ni = 1'b0;
        #1;
        total++;
        if ({smp_valid_o, busy_o, drop_cnt_o} !== 18'h0) begin
            bad++; $display("FAIL async_reset: got valid %b busy %b drops %h want 0 0 0", smp_valid_o, busy_o, drop_cnt_o);
        end
    endtask

    initial begin
        test_reset();
        test_periodic();
        test_csr_priority();
        test_backpressure();
        test_irq();
        test_back_to_back();
        test_abort();
        test_drops();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
